// File: rtl/sdram_avl_arbiter.sv
// sdram_avl_arbiter: shares the single avl slave port of sdram_controller between
// NUM_MASTERS avl masters. One owner at a time; the grant is locked for every request
// beat and, for reads, every returned word, then the arbiter re-arbitrates.
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest);
// otherwise round-robin starting from a pointer just past the previous winner.
// Handshake: a request beat transfers on a cycle where s_read|s_write and
// s_request_ready are both high; a response word transfers on a cycle where
// s_read_data_valid and s_resp_ready are both high.
// state_dbg exposes the FSM state (0 IDLE, 1 GRANT, 2 DRAIN).
module sdram_avl_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int BEAT_W      = 9
) (
   input  logic                     clk,
   input  logic                     rest_n,
   input  logic [NUM_MASTERS*32-1:0] m_address,
   input  logic [NUM_MASTERS*4-1:0]  m_byte_en,
   input  logic [NUM_MASTERS-1:0]    m_read,
   input  logic [NUM_MASTERS-1:0]    m_write,
   input  logic [NUM_MASTERS*32-1:0] m_write_data,
   input  logic [NUM_MASTERS-1:0]    m_begin_burst_transfer,
   input  logic [NUM_MASTERS*8-1:0]  m_burst_count,
   output logic [NUM_MASTERS-1:0]    m_request_ready,
   output logic [31:0]               m_read_data,
   output logic [NUM_MASTERS-1:0]    m_read_data_valid,
   input  logic [NUM_MASTERS-1:0]    m_resp_ready,
   output logic [31:0]               s_address,
   output logic [3:0]                s_byte_en,
   output logic                      s_read,
   output logic                      s_write,
   output logic [31:0]               s_write_data,
   output logic                      s_begin_burst_transfer,
   output logic [7:0]                s_burst_count,
   input  logic                      s_request_ready,
   input  logic [31:0]               s_read_data,
   input  logic                      s_read_data_valid,
   output logic                      s_resp_ready,
   output logic [NUM_MASTERS-1:0]    grant,
   output logic                      busy,
   output logic [1:0]                state_dbg
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [BEAT_W-1:0]  total, req_cnt, rsp_cnt;
   logic               txn_rd;
   logic [NUM_MASTERS-1:0] req_vec;
   logic               win_valid, win_begin, win_rd;
   logic [PTR_W-1:0]   win_idx;
   logic [7:0]         win_bc;
   logic               owner_rd, owner_wr;
   logic               req_fire, rsp_fire, start, go_idle;

   assign req_vec     = m_read | m_write;
   assign m_read_data = s_read_data;
   assign state_dbg   = state;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   // Fixed priority: lowest-index requester wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      win_bc    = '0;
      win_begin = 1'b0;
      win_rd    = 1'b0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (req_vec[k]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(k);
            win_bc    = m_burst_count[8*k +: 8];
            win_begin = m_begin_burst_transfer[k];
            win_rd    = m_read[k];
         end
      end
   end
`else
   logic [PTR_W-1:0] rr_ptr;

   // Round-robin: first requester found scanning upward from rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_valid = 1'b0;
      win_idx   = '0;
      win_bc    = '0;
      win_begin = 1'b0;
      win_rd    = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!win_valid && req_vec[idx]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(idx);
            win_bc    = m_burst_count[8*idx +: 8];
            win_begin = m_begin_burst_transfer[idx];
            win_rd    = m_read[idx];
         end
      end
   end

   // Pointer moves just past the winner each time a grant is issued.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n)
         rr_ptr <= '0;
      else if (start)
         rr_ptr <= (win_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : win_idx + PTR_W'(1);
   end
`endif

   // AND-OR mux of the owner's request fields; grant is one-hot or zero.
   always_comb begin
      s_address              = '0;
      s_byte_en              = '0;
      s_write_data           = '0;
      s_begin_burst_transfer = 1'b0;
      s_burst_count          = '0;
      owner_rd               = 1'b0;
      owner_wr               = 1'b0;
      s_resp_ready           = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant[i]) begin
            s_address              = s_address | m_address[32*i +: 32];
            s_byte_en              = s_byte_en | m_byte_en[4*i +: 4];
            s_write_data           = s_write_data | m_write_data[32*i +: 32];
            s_begin_burst_transfer = s_begin_burst_transfer | m_begin_burst_transfer[i];
            s_burst_count          = s_burst_count | m_burst_count[8*i +: 8];
            owner_rd               = owner_rd | m_read[i];
            // read wins when both strobes are set
            owner_wr               = owner_wr | (m_write[i] & ~m_read[i]);
            s_resp_ready           = s_resp_ready | m_resp_ready[i];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and per-state strobes toward slave and owner.
   always_comb begin
      state_nxt         = state;
      s_read            = 1'b0;
      s_write           = 1'b0;
      m_request_ready   = '0;
      m_read_data_valid = '0;
      busy              = 1'b0;
      req_fire          = 1'b0;
      rsp_fire          = 1'b0;
      start             = 1'b0;
      go_idle           = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               start     = 1'b1;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            busy              = 1'b1;
            s_read            = owner_rd;
            s_write           = owner_wr;
            m_request_ready   = grant & {NUM_MASTERS{s_request_ready}};
            m_read_data_valid = grant & {NUM_MASTERS{s_read_data_valid}};
            req_fire          = s_request_ready & (owner_rd | owner_wr);
            rsp_fire          = s_read_data_valid & s_resp_ready;
            if (req_fire && (req_cnt + BEAT_W'(1) == total)) begin
               if (!txn_rd || (rsp_cnt + BEAT_W'(rsp_fire) == total)) begin
                  go_idle   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy              = 1'b1;
            m_read_data_valid = grant & {NUM_MASTERS{s_read_data_valid}};
            rsp_fire          = s_read_data_valid & s_resp_ready;
            if (rsp_fire && (rsp_cnt + BEAT_W'(1) == total)) begin
               go_idle   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, transaction length and beat counters.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         grant   <= '0;
         total   <= '0;
         req_cnt <= '0;
         rsp_cnt <= '0;
         txn_rd  <= 1'b0;
      end else if (start) begin
         grant   <= NUM_MASTERS'(1) << win_idx;
         total   <= win_begin ? BEAT_W'(win_bc) + BEAT_W'(1) : BEAT_W'(1);
         req_cnt <= '0;
         rsp_cnt <= '0;
         txn_rd  <= win_rd;
      end else if (go_idle) begin
         grant   <= '0;
         req_cnt <= '0;
         rsp_cnt <= '0;
      end else begin
         if (req_fire) req_cnt <= req_cnt + BEAT_W'(1);
         if (rsp_fire) rsp_cnt <= rsp_cnt + BEAT_W'(1);
      end
   end

endmodule

// File: tb/tb_sdram_avl_arbiter.sv
// Directed bench for sdram_avl_arbiter: bench-side masters and a simple slave that
// answers each accepted read beat with one word; read data checked through exp_q.
module tb_sdram_avl_arbiter;

   localparam int N = 2;

   logic              clk = 1'b0;
   logic              rest_n;
   logic [N*32-1:0]   m_address;
   logic [N*4-1:0]    m_byte_en;
   logic [N-1:0]      m_read, m_write;
   logic [N*32-1:0]   m_write_data;
   logic [N-1:0]      m_begin_burst_transfer;
   logic [N*8-1:0]    m_burst_count;
   logic [N-1:0]      m_request_ready;
   logic [31:0]       m_read_data;
   logic [N-1:0]      m_read_data_valid;
   logic [N-1:0]      m_resp_ready;
   logic [31:0]       s_address;
   logic [3:0]        s_byte_en;
   logic              s_read, s_write;
   logic [31:0]       s_write_data;
   logic              s_begin_burst_transfer;
   logic [7:0]        s_burst_count;
   logic              s_request_ready;
   logic [31:0]       s_read_data;
   logic              s_read_data_valid;
   logic              s_resp_ready;
   logic [N-1:0]      grant;
   logic              busy;
   logic [1:0]        state_dbg;

   // clock / reset block
   always #5 clk = ~clk;

   sdram_avl_arbiter #(.NUM_MASTERS(N), .BEAT_W(9)) dut (
      .clk(clk), .rest_n(rest_n),
      .m_address(m_address), .m_byte_en(m_byte_en),
      .m_read(m_read), .m_write(m_write), .m_write_data(m_write_data),
      .m_begin_burst_transfer(m_begin_burst_transfer), .m_burst_count(m_burst_count),
      .m_request_ready(m_request_ready), .m_read_data(m_read_data),
      .m_read_data_valid(m_read_data_valid), .m_resp_ready(m_resp_ready),
      .s_address(s_address), .s_byte_en(s_byte_en), .s_read(s_read), .s_write(s_write),
      .s_write_data(s_write_data), .s_begin_burst_transfer(s_begin_burst_transfer),
      .s_burst_count(s_burst_count), .s_request_ready(s_request_ready),
      .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid),
      .s_resp_ready(s_resp_ready), .grant(grant), .busy(busy), .state_dbg(state_dbg)
   );

   int checks = 0;
   int errors = 0;

   // master models and logs
   int          beats_left[N], rsp_left[N], txns_left[N], bc_cfg[N], txn_idx[N];
   logic        is_rd[N];
   int          req_seen[N], rdv_seen[N];
   int          stall_left;
   logic        stalled;
   logic [31:0] rd_q[$];
   logic [31:0] exp_q[$];
   logic [N-1:0] order_q[$];
   int          gstart_q[$];
   int          cyc_g, drop_cyc, last_rsp_cyc, drain_cycles;
   logic [N-1:0] prev_grant;
   logic [31:0] rd_serial = 32'd0;
   logic        done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int i);
      beats_left[i] = bc_cfg[i] + 1;
      rsp_left[i]   = is_rd[i] ? bc_cfg[i] + 1 : 0;
      txn_idx[i]++;
   endtask

   task automatic setup(input int i, input int txns, input logic rd, input int bc);
      is_rd[i]      = rd;
      bc_cfg[i]     = bc;
      txns_left[i]  = txns;
      beats_left[i] = 0;
      rsp_left[i]   = 0;
      if (txns > 0) begin
         txns_left[i]--;
         load(i);
      end
   endtask

   task automatic clear_logs();
      order_q.delete();
      gstart_q.delete();
      for (int i = 0; i < N; i++) begin
         req_seen[i] = 0;
         rdv_seen[i] = 0;
      end
      cyc_g = 0; drop_cyc = -1; last_rsp_cyc = -1; drain_cycles = 0;
      prev_grant = '0;
   endtask

   // driver: master strobes/fields, resp_ready stall, slave answer
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         logic act;
         act = (beats_left[i] > 0) || (rsp_left[i] > 0);
         m_read[i]  = act && is_rd[i];
         m_write[i] = act && !is_rd[i];
         m_address[32*i +: 32]    = 32'h1000 * (i + 1) + 32'(txn_idx[i]);
         m_write_data[32*i +: 32] = 32'hA000_0000 | (32'(i) << 16) | 32'(beats_left[i]);
         m_byte_en[4*i +: 4]      = 4'hF;
         m_begin_burst_transfer[i] = (bc_cfg[i] != 0);
         m_burst_count[8*i +: 8]  = 8'(bc_cfg[i]);
         m_resp_ready[i]          = 1'b1;
      end
      stalled = 1'b0;
      if (stall_left > 0 && state_dbg == 2'd2) begin
         m_resp_ready[0] = 1'b0;
         stall_left--;
         stalled = 1'b1;
      end
      s_request_ready   = 1'b1;
      s_read_data_valid = (rd_q.size() > 0);
      s_read_data       = (rd_q.size() > 0) ? rd_q[0] : 32'd0;
   endtask

   // monitor + scoreboard, sampled #1 after the negedge drive
   task automatic sample();
      logic [31:0] e;
      check("req_ready_owner", 32'(m_request_ready & ~grant), 32'd0);
      check("rdv_owner", 32'(m_read_data_valid & ~grant), 32'd0);
      if (state_dbg == 2'd2) begin
         drain_cycles++;
         check("drain_s_read", 32'(s_read), 32'd0);
      end
      if (stalled) begin
         check("stall_resp_ready", 32'(s_resp_ready), 32'd0);
         check("stall_grant", 32'(grant), 32'd1);
      end
      if (grant != '0 && prev_grant == '0) begin
         order_q.push_back(grant);
         gstart_q.push_back(cyc_g);
      end
      if (grant != '0 && prev_grant != '0) check("grant_locked", 32'(grant), 32'(prev_grant));
      if (grant == '0 && prev_grant != '0) drop_cyc = cyc_g;
      prev_grant = grant;
      if (s_request_ready && (s_read || s_write)) begin
         for (int o = 0; o < N; o++)
            if (grant[o]) check("s_address", s_address, 32'h1000 * (o + 1) + 32'(txn_idx[o]));
      end
      if (s_request_ready && s_read) begin
         rd_q.push_back(32'hD000_0000 + rd_serial);
         exp_q.push_back(32'hD000_0000 + rd_serial);
         rd_serial++;
      end
      if (s_read_data_valid && s_resp_ready) void'(rd_q.pop_front());
      for (int i = 0; i < N; i++) begin
         if (m_read_data_valid[i]) rdv_seen[i]++;
         if (m_read_data_valid[i] && m_resp_ready[i]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("read_data", m_read_data, e);
            rsp_left[i]--;
            if (rsp_left[i] <= 0 && beats_left[i] <= 0) last_rsp_cyc = cyc_g;
         end
         if (m_request_ready[i] && (m_read[i] || m_write[i])) begin
            req_seen[i]++;
            beats_left[i]--;
         end
         if (beats_left[i] <= 0 && rsp_left[i] <= 0 && txns_left[i] > 0) begin
            txns_left[i]--;
            load(i);
         end
      end
      cyc_g++;
   endtask

   function automatic logic masters_done();
      logic d;
      d = 1'b1;
      for (int i = 0; i < N; i++)
         if (beats_left[i] > 0 || rsp_left[i] > 0 || txns_left[i] > 0) d = 1'b0;
      return d;
   endfunction

   // run until all master transactions finish or the cycle budget expires, then settle
   task automatic run(input int max_cycles, output logic ok);
      int n;
      n = 0;
      while (n < max_cycles && !masters_done()) begin
         @(negedge clk); drive(); #1; sample();
         n++;
      end
      ok = masters_done();
      if (ok) begin
         repeat (2) begin
            @(negedge clk); drive(); #1; sample();
         end
      end
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) setup(i, 0, 1'b0, 0);
      rd_q.delete();
      exp_q.delete();
      stall_left = 0;
      @(negedge clk);
      rest_n = 1'b0;
      drive();
      repeat (2) @(negedge clk);
      rest_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         txn_idx[i] = 0;
         setup(i, 0, 1'b0, 0);
      end
      stall_left = 0;
      clear_logs();
      rest_n = 1'b0;
      drive();
      s_read_data_valid = 1'b1;
      m_resp_ready = '1;
      #1;
      // reset state
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_s_rw", 32'({s_read, s_write}), 32'd0);
      check("rst_rdv", 32'(m_read_data_valid), 32'd0);
      check("rst_resp_ready", 32'(s_resp_ready), 32'd0);
      @(negedge clk);
      rest_n = 1'b1;

      // M0 single write, M1 idle
      clear_logs();
      setup(0, 1, 1'b0, 0);
      run(50, done);
      check("sw_done", 32'(done), 32'd1);
      check("sw_order_n", 32'(order_q.size()), 32'd1);
      check("sw_grant", 32'(order_q[0]), 32'd1);
      check("sw_latency", 32'(gstart_q[0]), 32'd1);
      check("sw_req_m0", 32'(req_seen[0]), 32'd1);
      check("sw_req_m1", 32'(req_seen[1]), 32'd0);
      check("sw_idle_after", 32'(state_dbg), 32'd0);
      check("sw_busy_after", 32'(busy), 32'd0);

      // reset in the middle of an M1 write burst
      clear_logs();
      setup(1, 1, 1'b0, 3);
      run(3, done);
      check("mid_beats", 32'(req_seen[1]), 32'd2);
      @(negedge clk);
      rest_n = 1'b0;
      s_read_data_valid = 1'b1;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_state", 32'(state_dbg), 32'd0);
      check("mid_rst_s_write", 32'(s_write), 32'd0);
      check("mid_rst_req_ready", 32'(m_request_ready), 32'd0);
      check("mid_rst_rdv", 32'(m_read_data_valid), 32'd0);
      do_reset();

      // both masters write bursts of 4, two each, round-robin
      clear_logs();
      setup(0, 2, 1'b0, 3);
      setup(1, 2, 1'b0, 3);
      run(100, done);
      check("rr_done", 32'(done), 32'd1);
      check("rr_order_n", 32'(order_q.size()), 32'd4);
      check("rr_order0", 32'(order_q[0]), 32'd1);
      check("rr_order1", 32'(order_q[1]), 32'd2);
      check("rr_order2", 32'(order_q[2]), 32'd1);
      check("rr_order3", 32'(order_q[3]), 32'd2);
      check("rr_gap", 32'(gstart_q[1]), 32'd6);
      check("rr_beats_m0", 32'(req_seen[0]), 32'd8);
      check("rr_beats_m1", 32'(req_seen[1]), 32'd8);

      // M1 read burst of 8, M0 idle
      do_reset();
      clear_logs();
      setup(1, 1, 1'b1, 7);
      run(100, done);
      check("rd_done", 32'(done), 32'd1);
      check("rd_grant", 32'(order_q[0]), 32'd2);
      check("rd_req_m1", 32'(req_seen[1]), 32'd8);
      check("rd_rdv_m1", 32'(rdv_seen[1]), 32'd8);
      check("rd_rdv_m0", 32'(rdv_seen[0]), 32'd0);
      check("rd_drain_cycles", 32'(drain_cycles), 32'd1);
      check("rd_last_word_cyc", 32'(last_rsp_cyc), 32'd9);
      check("rd_grant_drop", 32'(drop_cyc), 32'd10);
      check("rd_exp_empty", 32'(exp_q.size()), 32'd0);

      // M0 read burst of 4 stalls resp_ready 5 cycles in DRAIN, M1 write waits
      do_reset();
      clear_logs();
      setup(0, 1, 1'b1, 3);
      setup(1, 1, 1'b0, 0);
      stall_left = 5;
      run(100, done);
      check("st_done", 32'(done), 32'd1);
      check("st_stall_used", 32'(stall_left), 32'd0);
      check("st_order0", 32'(order_q[0]), 32'd1);
      check("st_order1", 32'(order_q[1]), 32'd2);
      check("st_m1_start", 32'(gstart_q[1]), 32'd12);
      check("st_drain_cycles", 32'(drain_cycles), 32'd6);
      check("st_rdv_m0", 32'(rdv_seen[0]), 32'd9);
      check("st_rdv_m1", 32'(rdv_seen[1]), 32'd0);
      check("st_req_m1", 32'(req_seen[1]), 32'd1);

      // M0 requests back to back (3 singles), M1 waiting with one single
      do_reset();
      clear_logs();
      setup(0, 3, 1'b0, 0);
      setup(1, 1, 1'b0, 0);
      run(100, done);
      check("pr_done", 32'(done), 32'd1);
      check("pr_order_n", 32'(order_q.size()), 32'd4);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      check("pr_order0", 32'(order_q[0]), 32'd1);
      check("pr_order1", 32'(order_q[1]), 32'd1);
      check("pr_order2", 32'(order_q[2]), 32'd1);
      check("pr_order3", 32'(order_q[3]), 32'd2);
`else
      check("pr_order0", 32'(order_q[0]), 32'd1);
      check("pr_order1", 32'(order_q[1]), 32'd2);
      check("pr_order2", 32'(order_q[2]), 32'd1);
      check("pr_order3", 32'(order_q[3]), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
